// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: runs one load/store per instruction over a
// req/ack port, stalls the upstream pipeline meanwhile and reports misalignment/timeouts.
module mem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_MemRead_In,
  input  logic        MEM_MemWrite_In,
  input  logic        MEM_RegWrite_In,
  input  logic        MEM_MemtoReg_In,
  input  logic [31:0] MEM_ALUresult_In,
  input  logic [31:0] MEM_WriteData_In,
  input  logic [4:0]  MEM_Index_WriteReg_In,
  output logic        Dmem_Req,
  output logic        Dmem_We,
  output logic [31:0] Dmem_Addr,
  output logic [31:0] Dmem_WData,
  input  logic        Dmem_Ack,
  input  logic [31:0] Dmem_RData,
  output logic        Stall_Out,
  output logic [31:0] ReadData_Out,
  output logic        RegWrite_Out,
  output logic        MemtoReg_Out,
  output logic [31:0] ALUresult_Out,
  output logic [4:0]  Index_WriteReg_Out,
  output logic        Fault_Out,
  output logic [31:0] Fault_Addr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt_p1;
  logic [31:0]      rdata_p1;
  logic             abort_p1;

  logic mem_op;
  logic op_bad;
  logic op_go;

  assign mem_op = MEM_MemRead_In | MEM_MemWrite_In;
  assign op_bad = (MEM_MemRead_In & MEM_MemWrite_In)
                | (mem_op & (MEM_ALUresult_In[1:0] != 2'b00));
  assign op_go  = mem_op & ~op_bad;

  assign MemtoReg_Out       = MEM_MemtoReg_In;
  assign ALUresult_Out      = MEM_ALUresult_In;
  assign Index_WriteReg_Out = MEM_Index_WriteReg_In;

  // Stall and writeback gating must react in the same cycle the op appears,
  // and must drop immediately while reset is held.
  always_comb begin
    Stall_Out    = 1'b0;
    RegWrite_Out = 1'b0;
    ReadData_Out = 32'd0;
    if (reset) begin
      case (state)
        IDLE: begin
          Stall_Out    = op_go;
          RegWrite_Out = MEM_RegWrite_In & ~mem_op;
        end
        REQ: Stall_Out = 1'b1;
        DONE: begin
          RegWrite_Out = MEM_RegWrite_In & ~abort_p1;
          ReadData_Out = rdata_p1;
        end
        default: ;
      endcase
    end
  end

  // Access sequencer: latch request in IDLE, wait for ack or timeout in REQ,
  // present result for one cycle in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      Dmem_Req   <= 1'b0;
      Dmem_We    <= 1'b0;
      Dmem_Addr  <= 32'd0;
      Dmem_WData <= 32'd0;
      Fault_Out  <= 1'b0;
      Fault_Addr <= 32'd0;
      cnt_p1     <= '0;
      rdata_p1   <= 32'd0;
      abort_p1   <= 1'b0;
    end else begin
      Fault_Out <= 1'b0;
      case (state)
        IDLE: begin
          if (op_go) begin
            Dmem_Req   <= 1'b1;
            Dmem_We    <= MEM_MemWrite_In;
            Dmem_Addr  <= MEM_ALUresult_In;
            Dmem_WData <= MEM_WriteData_In;
            cnt_p1     <= '0;
            abort_p1   <= 1'b0;
            state      <= REQ;
          end else if (op_bad) begin
            Fault_Out  <= 1'b1;
            Fault_Addr <= MEM_ALUresult_In;
          end
        end
        REQ: begin
          cnt_p1 <= cnt_p1 + 1'b1;
          if (Dmem_Ack) begin
            Dmem_Req <= 1'b0;
            Dmem_We  <= 1'b0;
            rdata_p1 <= Dmem_We ? 32'd0 : Dmem_RData;
            state    <= DONE;
          end else if (cnt_p1 == CNT_LAST) begin
            Dmem_Req   <= 1'b0;
            Dmem_We    <= 1'b0;
            Fault_Out  <= 1'b1;
            Fault_Addr <= Dmem_Addr;
            rdata_p1   <= 32'd0;
            abort_p1   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          abort_p1 <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory controller between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Runs load/store accesses over a variable-latency req/ack data-memory port and stalls the upstream pipeline until each access completes.
- Inserts a bubble into MEM/WB while stalled, because MEM/WB has no enable.
- Flags misaligned accesses and memory timeouts.

Parameters:
TIMEOUT, 255, number of REQ cycles without Dmem_Ack before the access is aborted with a fault (1..255).
CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
MEM_MemRead_In  in  1  load in MEM stage
MEM_MemWrite_In  in  1  store in MEM stage
MEM_RegWrite_In  in  1  writeback enable from EX/MEM
MEM_MemtoReg_In  in  1  writeback select from EX/MEM
MEM_ALUresult_In  in  32  ALU result / byte address
MEM_WriteData_In  in  32  store data
MEM_Index_WriteReg_In  in  5  destination register
Dmem_Req  out  1  access request, held until ack or abort
Dmem_We  out  1  1=write, valid with Dmem_Req
Dmem_Addr  out  32  latched word address
Dmem_WData  out  32  latched store data
Dmem_Ack  in  1  one-cycle completion strobe
Dmem_RData  in  32  read data, valid with Dmem_Ack
Stall_Out  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
ReadData_Out  out  32  load data to MEM/WB
RegWrite_Out  out  1  gated writeback enable to MEM/WB
MemtoReg_Out  out  1  passthrough of MEM_MemtoReg_In
ALUresult_Out  out  32  passthrough of MEM_ALUresult_In
Index_WriteReg_Out  out  5  passthrough of MEM_Index_WriteReg_In
Fault_Out  out  1  one-cycle fault pulse
Fault_Addr  out  32  address of the last fault, sticky

Behaviour:
- Reset low (asynchronous, takes effect immediately):
  - state=IDLE; Dmem_Req, Dmem_We, Dmem_Addr, Dmem_WData, Stall_Out, Fault_Out, Fault_Addr, ReadData_Out, timeout counter and rdata register all 0.
  - RegWrite_Out forced 0.
  - Reset asserted in REQ drops Dmem_Req at once, and any later ack is ignored.
- States are IDLE, REQ and DONE.
- IDLE, no memory op: Stall_Out=0; RegWrite_Out=MEM_RegWrite_In, combinational; ReadData_Out=0.
- IDLE, memory op requested (MemRead xor MemWrite), address[1:0]==0:
  - Stall_Out=1 and RegWrite_Out=0, combinationally in the same cycle.
  - At the next edge: latch Dmem_Addr, Dmem_WData and Dmem_We=MemWrite; clear the counter; go to REQ.
- REQ:
  - Dmem_Req=1, Stall_Out=1, RegWrite_Out=0; counter increments each cycle.
  - Dmem_Ack=1: capture Dmem_RData (loads only; 0 for stores) and go to DONE. An ack in the first REQ cycle is legal, so the minimum is 1 REQ cycle.
  - Counter reaches TIMEOUT with no ack: drop the request; Fault_Out=1 for one cycle; Fault_Addr=Dmem_Addr; rdata=0; go to DONE with the abort flag set.
- DONE, exactly one cycle:
  - Stall_Out=0; ReadData_Out=rdata; Dmem_Req=0.
  - RegWrite_Out=MEM_RegWrite_In, or 0 if the abort flag is set.
  - MEM/WB captures at the closing edge while EX/MEM advances. Next state is IDLE.
- Load latency: 1 + N + 1 cycles for ack after N REQ cycles; Stall_Out is high for 1+N cycles.
- Misaligned (address[1:0]!=0) or both MemRead and MemWrite high, in IDLE:
  - No request, no stall, RegWrite_Out=0.
  - Fault_Out pulses in the next cycle; Fault_Addr=MEM_ALUresult_In.
  - The instruction retires as a bubble.
- Dmem_Ack outside REQ is ignored.
- Passthrough outputs are always combinational from the EX/MEM inputs, which stay stable while Stall_Out is high.

Test Plan:
- Plain ALU op: RegWrite=1, addr=0x40, no MemRead/MemWrite -> no Dmem_Req, Stall_Out=0, RegWrite_Out=1 in the same cycle, ALUresult_Out=0x40.
- Load with 3-cycle ack: addr=0x100, Dmem_RData=0xDEADBEEF -> Stall_Out high 4 cycles, Dmem_Req high 3 cycles with Addr=0x100 and We=0; then DONE with ReadData_Out=0xDEADBEEF and RegWrite_Out=1; RegWrite_Out=0 throughout the stall.
- Store with same-cycle ack: addr=0x8, data=0x1234 -> Dmem_Req and Dmem_We high exactly 1 cycle with WData=0x1234; Stall_Out 2 cycles; ReadData_Out=0.
- Timeout: TIMEOUT=4, load at addr=0x20, never ack -> Dmem_Req high 4 cycles then low; Fault_Out one pulse; Fault_Addr=0x20; DONE with RegWrite_Out=0.
- Misaligned load at addr=0x22 -> no Dmem_Req, no stall, Fault_Out pulse, Fault_Addr=0x22, RegWrite_Out=0. Also MemRead=MemWrite=1 at 0x30 -> same fault behaviour.
- Reset low in the 2nd REQ cycle -> Dmem_Req, Stall_Out and RegWrite_Out drop immediately (asynchronously); an ack after release is ignored; state is IDLE.
